// File: rtl/axi_rd_pkg.sv
// Shared encodings and burst address arithmetic for the AXI4 read responder.
// Imported by the address generator and the responder top.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // WRAP uses a mask, so it is only meaningful for power-of-two beat counts.
  // Other lengths are rejected as SLVERR before their addresses matter.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
    logic [63:0] bytes;
    logic [63:0] mask;
    bytes = 64'd1 << size;
    mask  = (({56'd0, len} + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: axi_next_addr = addr;
      BURST_WRAP:  axi_next_addr = (addr & ~mask) | ((addr + bytes) & mask);
      default:     axi_next_addr = addr + bytes;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address / read data channel bundle.
// The responder connects through the slave modport.
interface axi_rd_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) ();

  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

endinterface

// File: rtl/axi_beat_addr_gen.sv
// Beat address sequencer: holds the address of the beat currently presented,
// counts beats, and offers the address whose word must be fetched next.
module axi_beat_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_advance,
  input  logic                  i_done,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_fetch_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cnt;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_next_addr  = ADDR_WIDTH'(axi_next_addr(64'(r_addr), r_size, r_len, r_burst));
  assign o_fetch_addr = i_start ? i_addr : w_next_addr;
  assign o_last       = r_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_last  <= 1'b0;
    end else if (i_start) begin
      r_addr  <= i_addr;
      r_cnt   <= '0;
      r_len   <= i_len;
      r_size  <= i_size;
      r_burst <= i_burst;
      r_last  <= (i_len == 8'd0);
    end else if (i_advance) begin
      r_addr  <= w_next_addr;
      r_cnt   <= r_cnt + 8'd1;
      r_last  <= ((r_cnt + 8'd1) == r_len);
    end else if (i_done) begin
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only subordinate over a preloadable 64-bit word array.
// One burst in flight; R beats are registered with single-cycle AR-to-R latency.
module axi_rd_responder
  import axi_rd_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_rd_responder_if.slave            s_axi,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0]        ld_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_ready_en;
  logic                  w_arready;
  logic                  w_rvalid;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_advance;
  logic                  w_done;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_ar_mask;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_ar_bad;
  logic                  w_range_err;
  logic                  w_beat_err;
  logic                  r_burst_err;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_e                 r_rresp;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  assign w_ar_hs   = s_axi.s_axi_arvalid & w_arready;
  assign w_r_hs    = w_rvalid & s_axi.s_axi_rready;
  assign w_advance = w_r_hs & ~w_last;
  assign w_done    = w_r_hs & w_last;

  axi_beat_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk          (clk),
    .rst_n        (reset),
    .i_start      (w_ar_hs),
    .i_advance    (w_advance),
    .i_done       (w_done),
    .i_addr       (s_axi.s_axi_araddr),
    .i_len        (s_axi.s_axi_arlen),
    .i_size       (s_axi.s_axi_arsize),
    .i_burst      (s_axi.s_axi_arburst),
    .o_fetch_addr (w_fetch_addr),
    .o_last       (w_last)
  );

  // r_ready_en keeps arready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs) w_state_next = BURST;
      BURST:   if (w_done)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_arready = r_ready_en && (r_state == IDLE);
    w_rvalid  = (r_state == BURST);
  end

  // Burst-wide errors: reserved burst type, oversized beat, or a malformed WRAP.
  assign w_ar_mask = (ADDR_WIDTH'(1) << s_axi.s_axi_arsize) - ADDR_WIDTH'(1);
  assign w_ar_bad  = (s_axi.s_axi_arburst == BURST_RSVD) ||
                     (s_axi.s_axi_arsize > 3'd3) ||
                     ((s_axi.s_axi_arburst == BURST_WRAP) &&
                      (!(s_axi.s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                       ((s_axi.s_axi_araddr & w_ar_mask) != '0)));

  assign w_offset    = w_fetch_addr - BASE_ADDR;
  assign w_word      = w_offset >> 3;
  assign w_range_err = (w_fetch_addr < BASE_ADDR) || (w_word >= ADDR_WIDTH'(MEM_WORDS));
  assign w_idx       = w_word[IDX_W-1:0];
  assign w_beat_err  = (w_ar_hs ? w_ar_bad : r_burst_err) | w_range_err;

  // NOTE: the backing array has no reset so preloaded contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end

  // Beat data is fetched at the edge that makes the beat current and then held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rid       <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_burst_err <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rid       <= s_axi.s_axi_arid;
        r_burst_err <= w_ar_bad;
      end
      if (w_ar_hs || w_advance) begin
        r_rdata <= w_beat_err ? '0 : r_mem[w_idx];
        r_rresp <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_rvalid  = w_rvalid;
  assign s_axi.s_axi_rid     = r_rid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rlast   = w_last;

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel subordinate backed by an internal 64-bit-wide memory array; serves the AR/R requests issued by the instruction-fetch front end (8-beat 64-bit WRAP bursts) plus INCR/FIXED bursts.
- Sits on the bus-side of the fetch path in simulation and FPGA bring-up; memory is preloaded through a side load port before reset release.
- One outstanding transaction; write channels are out of scope.

Parameters:
- ID_WIDTH, 13, width of arid/rid
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, beat width (fixed 64; other values unsupported)
- MEM_WORDS, 4096, depth of backing array in 64-bit words
- BASE_ADDR, 64'h0, byte address of word 0

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- s_axi_arid  in  ID_WIDTH  request id
- s_axi_araddr  in  ADDR_WIDTH  start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_arsize  in  3  log2 bytes per beat (0..3)
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_arvalid  in  1  request valid
- s_axi_arready  out  1  request accepted
- s_axi_rid  out  ID_WIDTH  echoed id
- s_axi_rdata  out  64  aligned 64-bit word containing beat address
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final beat
- s_axi_rvalid  out  1  beat valid
- s_axi_rready  in  1  beat accepted
- ld_en  in  1  preload write strobe
- ld_idx  in  $clog2(MEM_WORDS)  preload word index
- ld_data  in  64  preload word

Behaviour:
- Reset (reset==0, async): state IDLE; arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. Memory contents untouched. First cycle after release: arready=1.
- States: IDLE (arready=1, rvalid=0) -> on arvalid&&arready latch id/addr/len/size/burst, beat counter=0, go BURST. BURST (arready=0, rvalid=1) -> on rvalid&&rready with rlast go IDLE, else advance beat. First rvalid is the cycle after AR handshake (1-cycle latency); no rvalid bubbles between beats while rready held high.
- R outputs are registered; rid/rdata/rresp/rlast held stable while rvalid&&!rready.
- rlast=1 exactly when beat counter==arlen.
- Next address (bytes=1<<size): FIXED unchanged; INCR addr+bytes; WRAP bound=(len+1)*bytes, next=(addr & ~(bound-1)) | ((addr+bytes) & (bound-1)).
- Word index = (addr-BASE_ADDR)>>3; rdata = mem[index], narrow beats return full word (master selects lanes).
- SLVERR per beat, rdata=0: address below BASE_ADDR or index>=MEM_WORDS; WRAP with len not in {1,3,7,15}, or unaligned WRAP start (addr not multiple of bytes), marks every beat of that burst SLVERR. arburst==11 treated as SLVERR for all beats. Burst length always honoured (arlen+1 beats) regardless of error.
- INCR crossing a 4KB boundary: no check, addresses increment linearly.
- ld_en writes mem[ld_idx] at clk edge; ld_en to the same word being returned mid-burst: new data visible only on the next beat fetch (current held beat unchanged).
- Reset mid-burst: burst abandoned immediately, rvalid drops asynchronously, no further beats.

Decomposition:
- Package axi_rd_pkg: burst encodings (BURST_FIXED/INCR/WRAP), resp encodings (RESP_OKAY/RESP_SLVERR), state enum {IDLE, BURST}, function axi_next_addr(addr,size,len,burst).
- One sub-module natural: axi_beat_addr_gen (registered current address, beat counter, rlast, wrap arithmetic); top holds FSM, memory array and response registers.

Test Plan:
- Preload word k = 64'hA000_0000_0000_0000+k; WRAP len=7 size=3 addr=BASE+0x18 -> beats words 3,4,5,6,7,0,1,2, rresp=00, rlast only on beat 8, rid echoed (e.g. 13'h5).
- Same burst, rready toggled 1-0-0-1 pattern -> each beat held stable during stall, exactly 8 handshakes, arready stays 0 until after last.
- INCR len=3 starting at index MEM_WORDS-2 -> beats 1-2 OKAY with data, beats 3-4 SLVERR rdata=0, still 4 beats with rlast on 4th.
- WRAP len=2 -> 3 beats all SLVERR; next request accepted normally afterwards.
- Back-to-back: arvalid held with second request during burst -> accepted in first IDLE cycle after rlast handshake, first beat of second burst 1 cycle later.
- Assert reset low during beat 4 of an 8-beat burst -> rvalid=0 and arready=0 same cycle; after release, arready=1 and a new burst returns correct data.
